// File: rtl/avr_seq.sv
// avr_seq: instruction sequencer between fetch and the execute datapath.
// Chooses the PC source every cycle and gates instruction commit. It also
// covers the multi-cycle cases: pipeline priming after reset, branch flush,
// two-word instructions (JMP/CALL/LDS/STS) and two-cycle ADIW/SBIW.
//
// state  | meaning
// -------+----------------------------------------------------------
// RESET  | first cycle after reset release, PC forced to zero
// PRIME  | fetch pipeline filling, nothing commits
// RUN    | decode and commit single-cycle ops
// FLUSH  | discard the word fetched behind a taken jump
// FETCH2 | second word of JMP/CALL (jump) or LDS/STS (data)
// MULTI  | second cycle of ADIW/SBIW
module avr_seq (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] i_instr,
   input  logic        i_stall_req,
   output logic [2:0]  o_pc_select,
   output logic [15:0] o_pc_jmp,
   output logic        o_exec_en,
   output logic [15:0] o_exec_instr,
   output logic [15:0] o_exec_word2,
   output logic        o_exec_phase
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_PRIME  = 3'd1,
      S_RUN    = 3'd2,
      S_FLUSH  = 3'd3,
      S_FETCH2 = 3'd4,
      S_MULTI  = 3'd5
   } state_t;

   localparam logic [2:0] PC_ZERO = 3'b000;
   localparam logic [2:0] PC_HOLD = 3'b001;
   localparam logic [2:0] PC_INC  = 3'b010;
   localparam logic [2:0] PC_REL  = 3'b100;
   localparam logic [2:0] PC_ABS  = 3'b101;

   state_t      r_state;
   logic [15:0] r_first_word;
   logic        r_jump_flav;

   state_t      w_next;
   logic        w_latch;
   logic        w_latch_jump;
   logic        w_is_rjmp;
   logic        w_is_jmp;
   logic        w_is_lds;
   logic        w_is_adiw;
   logic        w_stall;

   // Decode the opcode classes the sequencer cares about.
   always_comb begin
      w_is_rjmp = (i_instr[15:12] == 4'b1100);
      w_is_jmp  = (i_instr[15:9] == 7'b1001010) && (i_instr[3:2] == 2'b11);
      w_is_lds  = (i_instr[15:10] == 6'b100100) && (i_instr[3:0] == 4'b0000);
      w_is_adiw = (i_instr[15:9] == 7'b1001011);
   end

   // Output and next-state decode; stall overrides the PC/commit, reset overrides all.
   always_comb begin
      o_pc_select  = PC_ZERO;
      o_pc_jmp     = 16'h0000;
      o_exec_en    = 1'b0;
      o_exec_instr = i_instr;
      o_exec_word2 = 16'h0000;
      o_exec_phase = 1'b0;
      w_next       = r_state;
      w_latch      = 1'b0;
      w_latch_jump = 1'b0;
      w_stall      = 1'b0;

      case (r_state)
         S_RESET: begin
            o_pc_select = PC_ZERO;
            w_next      = S_PRIME;
         end
         S_PRIME: begin
            o_pc_select = PC_INC;
            w_next      = S_RUN;
         end
         S_RUN: begin
            w_stall = i_stall_req;
            if (w_is_rjmp) begin
               o_pc_select = PC_REL;
               o_pc_jmp    = {{4{i_instr[11]}}, i_instr[11:0]};
               o_exec_en   = 1'b1;
               w_next      = S_FLUSH;
            end else if (w_is_jmp) begin
               o_pc_select  = PC_INC;
               w_next       = S_FETCH2;
               w_latch      = 1'b1;
               w_latch_jump = 1'b1;
            end else if (w_is_lds) begin
               o_pc_select = PC_INC;
               w_next      = S_FETCH2;
               w_latch     = 1'b1;
            end else if (w_is_adiw) begin
               o_pc_select = PC_HOLD;
               o_exec_en   = 1'b1;
               w_next      = S_MULTI;
               w_latch     = 1'b1;
            end else begin
               o_pc_select = PC_INC;
               o_exec_en   = 1'b1;
            end
         end
         S_FETCH2: begin
            w_stall = i_stall_req;
            if (r_jump_flav) begin
               o_pc_select = PC_ABS;
               o_pc_jmp    = i_instr;
               w_next      = S_FLUSH;
            end else begin
               o_pc_select  = PC_INC;
               o_exec_en    = 1'b1;
               o_exec_instr = r_first_word;
               o_exec_word2 = i_instr;
               w_next       = S_RUN;
            end
         end
         S_MULTI: begin
            w_stall      = i_stall_req;
            o_pc_select  = PC_INC;
            o_exec_en    = 1'b1;
            o_exec_phase = 1'b1;
            o_exec_instr = r_first_word;
            w_next       = S_RUN;
         end
         S_FLUSH: begin
            w_stall     = i_stall_req;
            o_pc_select = PC_INC;
            w_next      = S_RUN;
         end
         default: begin
            w_next = S_RESET;
         end
      endcase

      if (w_stall) begin
         o_pc_select = PC_HOLD;
         o_exec_en   = 1'b0;
         w_next      = r_state;
         w_latch     = 1'b0;
      end

      if (RST) begin
         o_pc_select  = PC_ZERO;
         o_pc_jmp     = 16'h0000;
         o_exec_en    = 1'b0;
         o_exec_instr = 16'h0000;
         o_exec_word2 = 16'h0000;
         o_exec_phase = 1'b0;
         w_next       = S_RESET;
         w_latch      = 1'b0;
      end
   end

   // State, latched first word and FETCH2 flavour.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_RESET;
         r_first_word <= 16'h0000;
         r_jump_flav  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_first_word <= i_instr;
            r_jump_flav  <= w_latch_jump;
         end
      end
   end

endmodule

// File: tb/tb_avr_seq.sv
// Bench for avr_seq: directed scenarios from the sequencing rules followed by
// randomized instruction/stall/reset traffic, all checked every cycle against
// a slot-queue reference model.
module tb_avr_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] i_instr = 16'h0000;
   logic        i_stall_req = 1'b0;
   logic [2:0]  o_pc_select;
   logic [15:0] o_pc_jmp;
   logic        o_exec_en;
   logic [15:0] o_exec_instr;
   logic [15:0] o_exec_word2;
   logic        o_exec_phase;

   avr_seq dut (
      .CLK          (CLK),
      .RST          (RST),
      .i_instr      (i_instr),
      .i_stall_req  (i_stall_req),
      .o_pc_select  (o_pc_select),
      .o_pc_jmp     (o_pc_jmp),
      .o_exec_en    (o_exec_en),
      .o_exec_instr (o_exec_instr),
      .o_exec_word2 (o_exec_word2),
      .o_exec_phase (o_exec_phase)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference model: the instruction stream is a sequence of cycle "slots".
   // When no follow-up slot is pending, the presented word is decoded and the
   // slots it will need afterwards are queued.
   typedef enum int {K_RESET, K_PRIME, K_FLUSH, K_JMP2, K_DATA2, K_MULTI} kind_t;
   typedef struct {kind_t kind; logic [15:0] fw;} slot_t;
   slot_t pend[$];

   logic [2:0]  e_pc;
   logic [15:0] e_jmp, e_ei, e_w2;
   logic        e_en, e_ph;

   // Classify a word: 0 other, 1 RJMP, 2 JMP/CALL, 3 LDS/STS, 4 ADIW/SBIW.
   function automatic int classify(input logic [15:0] w);
      if ((w & 16'hF000) == 16'hC000) return 1;
      if ((w & 16'hFE0C) == 16'h940C) return 2;
      if ((w & 16'hFC0F) == 16'h9000) return 3;
      if ((w & 16'hFE00) == 16'h9600) return 4;
      return 0;
   endfunction

   // Compute expectations for the current inputs and advance the model to the next edge.
   task automatic model_cycle(input logic r, input logic [15:0] w, input logic s);
      slot_t sl;
      int    c;
      e_pc = 3'd0; e_jmp = 0; e_en = 0; e_ei = w; e_w2 = 0; e_ph = 0;
      if (r) begin
         e_ei = 0;
         pend.delete();
         pend.push_back('{K_RESET, 16'h0});
         pend.push_back('{K_PRIME, 16'h0});
      end else if (pend.size() > 0 && pend[0].kind == K_RESET) begin
         e_pc = 3'b000;
         void'(pend.pop_front());
      end else if (pend.size() > 0 && pend[0].kind == K_PRIME) begin
         e_pc = 3'b010;
         void'(pend.pop_front());
      end else if (pend.size() > 0) begin
         sl = pend[0];
         case (sl.kind)
            K_FLUSH: e_pc = 3'b010;
            K_JMP2:  begin e_pc = 3'b101; e_jmp = w; end
            K_DATA2: begin e_pc = 3'b010; e_en = 1; e_ei = sl.fw; e_w2 = w; end
            default: begin e_pc = 3'b010; e_en = 1; e_ph = 1; e_ei = sl.fw; end
         endcase
         if (s) begin e_pc = 3'b001; e_en = 0; end
         else void'(pend.pop_front());
      end else begin
         c = classify(w);
         case (c)
            1: begin e_pc = 3'b100; e_jmp = 16'(signed'(w[11:0])); e_en = 1; end
            2: e_pc = 3'b010;
            3: e_pc = 3'b010;
            4: e_pc = 3'b001;
            default: begin e_pc = 3'b010; e_en = 1; end
         endcase
         if (c == 4) e_en = 1;
         if (s) begin
            e_pc = 3'b001; e_en = 0;
         end else begin
            case (c)
               1: pend.push_back('{K_FLUSH, 16'h0});
               2: begin pend.push_back('{K_JMP2, w}); pend.push_back('{K_FLUSH, 16'h0}); end
               3: pend.push_back('{K_DATA2, w});
               4: pend.push_back('{K_MULTI, w});
               default: ;
            endcase
         end
      end
   endtask

   // One clock cycle: apply inputs, check all outputs mid-cycle against the model.
   task automatic cyc(input logic r, input logic [15:0] w, input logic s);
      @(posedge CLK);
      #1;
      RST = r; i_instr = w; i_stall_req = s;
      #4;
      model_cycle(r, w, s);
      chk("pc_select",  32'(o_pc_select),  32'(e_pc));
      chk("pc_jmp",     32'(o_pc_jmp),     32'(e_jmp));
      chk("exec_en",    32'(o_exec_en),    32'(e_en));
      chk("exec_instr", 32'(o_exec_instr), 32'(e_ei));
      chk("exec_word2", 32'(o_exec_word2), 32'(e_w2));
      chk("exec_phase", 32'(o_exec_phase), 32'(e_ph));
   endtask

   logic [15:0] w_r;
   int          cat;
   int          rst_left;

   initial begin
      // Reset and priming.
      repeat (3) begin
         cyc(1, 16'h0000, 0);
         chk("rst_pc", 32'(o_pc_select), 32'h0);
         chk("rst_en", 32'(o_exec_en), 32'h0);
      end
      cyc(0, 16'h0000, 0);
      chk("reset_cyc_pc", 32'(o_pc_select), 32'h0);
      cyc(0, 16'h0000, 0);
      chk("prime_pc", 32'(o_pc_select), 32'h2);
      chk("prime_en", 32'(o_exec_en), 32'h0);
      cyc(0, 16'h0000, 0);
      chk("nop_pc", 32'(o_pc_select), 32'h2);
      chk("nop_en", 32'(o_exec_en), 32'h1);

      // RJMP backwards by 2, then its flush slot.
      cyc(0, 16'hCFFE, 0);
      chk("rjmp_pc", 32'(o_pc_select), 32'h4);
      chk("rjmp_jmp", 32'(o_pc_jmp), 32'hFFFE);
      chk("rjmp_en", 32'(o_exec_en), 32'h1);
      cyc(0, 16'hE0F5, 0);
      chk("rjmp_flush_en", 32'(o_exec_en), 32'h0);
      cyc(0, 16'hE0F5, 0);
      chk("rjmp_back_run", 32'(o_exec_en), 32'h1);

      // JMP 0x0123.
      cyc(0, 16'h940C, 0);
      chk("jmp1_pc", 32'(o_pc_select), 32'h2);
      cyc(0, 16'h0123, 0);
      chk("jmp2_pc", 32'(o_pc_select), 32'h5);
      chk("jmp2_jmp", 32'(o_pc_jmp), 32'h0123);
      cyc(0, 16'h1111, 0);
      chk("jmp3_en", 32'(o_exec_en), 32'h0);

      // LDS r16, 0x0060.
      cyc(0, 16'h9100, 0);
      cyc(0, 16'h0060, 0);
      chk("lds_en", 32'(o_exec_en), 32'h1);
      chk("lds_ei", 32'(o_exec_instr), 32'h9100);
      chk("lds_w2", 32'(o_exec_word2), 32'h0060);

      // ADIW.
      cyc(0, 16'h9601, 0);
      chk("adiw1_pc", 32'(o_pc_select), 32'h1);
      chk("adiw1_en", 32'(o_exec_en), 32'h1);
      cyc(0, 16'h0000, 0);
      chk("adiw2_ph", 32'(o_exec_phase), 32'h1);
      chk("adiw2_ei", 32'(o_exec_instr), 32'h9601);

      // JMP with a two-cycle stall in FETCH2.
      cyc(0, 16'h940C, 0);
      repeat (2) begin
         cyc(0, 16'h0123, 1);
         chk("stall_pc", 32'(o_pc_select), 32'h1);
         chk("stall_en", 32'(o_exec_en), 32'h0);
      end
      cyc(0, 16'h0123, 0);
      chk("after_stall_pc", 32'(o_pc_select), 32'h5);
      chk("after_stall_jmp", 32'(o_pc_jmp), 32'h0123);

      // Reset during FLUSH.
      cyc(1, 16'h0000, 0);
      chk("rst_flush_pc", 32'(o_pc_select), 32'h0);
      cyc(0, 16'h0000, 0);
      cyc(0, 16'h0000, 0);
      cyc(0, 16'h0000, 0);
      chk("rst_flush_run", 32'(o_exec_en), 32'h1);

      // Randomized traffic.
      rst_left = 0;
      for (int n = 0; n < 3000; n++) begin
         cat = $urandom_range(0, 9);
         w_r = 16'($urandom);
         case (cat)
            0, 1: w_r = {4'hC, w_r[11:0]};
            2:    w_r = {7'b1001010, w_r[8:4], 2'b11, w_r[0]};
            3:    w_r = {6'b100100, w_r[9:4], 4'h0};
            4:    w_r = {7'b1001011, w_r[8:0]};
            default: ;
         endcase
         if (rst_left == 0 && $urandom_range(0, 99) == 0) rst_left = $urandom_range(1, 2);
         cyc(rst_left > 0, w_r, $urandom_range(0, 4) == 0);
         if (rst_left > 0) rst_left--;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
